inbuf_vc: RTL and testbench

//  Router input-port stage: per-VC flit FIFOs, head-flit detection, sharing of one route-compute

---
 rtl/noc_pkg.sv | 22 ++
 rtl/noc_fifo.sv | 37 +++
 rtl/inbuf_vc.sv | 152 +++++++++++++++
 tb/tb_inbuf_vc.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC router types: flit encoding, per-VC state and global widths.
package noc_pkg;
  localparam int ENTRY_W = 8;
  localparam int PORT_W  = 3;
  localparam int FLIT_W  = ENTRY_W + 2;

  localparam logic [1:0] FT_BODY     = 2'b00;
  localparam logic [1:0] FT_HEAD     = 2'b01;
  localparam logic [1:0] FT_TAIL     = 2'b10;
  localparam logic [1:0] FT_HEADTAIL = 2'b11;

  typedef enum logic [1:0] {VC_IDLE, VC_RC, VC_ACTIVE} vc_state_e;

  // Type bit 0 marks a packet start, bit 1 marks a packet end.
  function automatic logic ft_is_head(input logic [1:0] t);
    return t[0];
  endfunction

  function automatic logic ft_is_tail(input logic [1:0] t);
    return t[1];
  endfunction
endpackage

// File: rtl/noc_fifo.sv
// Single-VC flit FIFO; pointers carry an extra wrap bit to separate full from empty.
module noc_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_front,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wp, r_rp;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (i_push) r_wp <= r_wp + 1'b1;
      if (i_pop)  r_rp <= r_rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wp[AW-1:0]] <= i_data;
  end

  assign o_front = r_mem[r_rp[AW-1:0]];
  assign o_empty = (r_wp == r_rp);
  assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
endmodule

// File: rtl/inbuf_vc.sv
// Router input port: per-VC FIFOs, shared route compute, route hold until tail,
// switch requests, registered flit output and credit return.
module inbuf_vc import noc_pkg::*; #(
  parameter  int VCH_NUM   = 2,
  parameter  int BUF_DEPTH = 4,
  localparam int VCH_W     = $clog2(VCH_NUM)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        valid_i,
  input  logic [FLIT_W-1:0]           flit_i,
  input  logic [VCH_W-1:0]            vch_i,
  output logic                        credit_o,
  output logic [VCH_W-1:0]            credit_vch_o,
  output logic                        rc_en_o,
  output logic [ENTRY_W-1:0]          rc_addr_o,
  output logic [ENTRY_W-1:0]          rc_vch_o,
  input  logic [PORT_W-1:0]           rc_port_i,
  input  logic [VCH_W-1:0]            rc_vch_i,
  output logic [VCH_NUM-1:0]          req_o,
  output logic [VCH_NUM*PORT_W-1:0]   req_port_o,
  input  logic [VCH_NUM-1:0]          grant_i,
  output logic                        flit_vld_o,
  output logic [FLIT_W-1:0]           flit_o,
  output logic [PORT_W-1:0]           out_port_o,
  output logic [VCH_W-1:0]            out_vch_o,
  output logic                        err_o
);
  logic [VCH_NUM-1:0][FLIT_W-1:0] w_front;
  logic [VCH_NUM-1:0]             w_empty, w_full, w_push, w_pop, w_req, w_elig, w_bad;
  vc_state_e                      r_state [VCH_NUM];
  logic [VCH_NUM-1:0][PORT_W-1:0] r_port;
  logic [VCH_NUM-1:0][VCH_W-1:0]  r_ovc;
  logic [VCH_W-1:0]               r_rc_ptr, w_rc_win, w_gnt_v, w_dis_v, w_idx;
  logic                           w_rc_vld, w_gnt_vld, w_dis_vld, w_ovf;
  logic                           r_flit_vld, r_credit, r_err;
  logic [FLIT_W-1:0]              r_flit;
  logic [PORT_W-1:0]              r_out_port;
  logic [VCH_W-1:0]               r_out_vch, r_credit_vch;

  for (genvar v = 0; v < VCH_NUM; v++) begin : g_vc
    // A full FIFO still accepts a write when the same cycle pops it.
    assign w_push[v] = valid_i && (vch_i == VCH_W'(v)) && (!w_full[v] || w_pop[v]);
    assign w_req[v]  = (r_state[v] == VC_ACTIVE) && !w_empty[v];
    // An IDLE VC with a head at its front competes for RC in the same cycle.
    assign w_elig[v] = (r_state[v] == VC_RC) ||
                       ((r_state[v] == VC_IDLE) && !w_empty[v] && ft_is_head(w_front[v][FLIT_W-1 -: 2]));
    assign w_bad[v]  = (r_state[v] == VC_IDLE) && !w_empty[v] && !ft_is_head(w_front[v][FLIT_W-1 -: 2]);
    assign w_pop[v]  = (w_gnt_vld && (w_gnt_v == VCH_W'(v))) || (w_dis_vld && (w_dis_v == VCH_W'(v)));
    assign req_port_o[v*PORT_W +: PORT_W] = r_port[v];

    noc_fifo #(.W(FLIT_W), .DEPTH(BUF_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push[v]),
      .i_pop   (w_pop[v]),
      .i_data  (flit_i),
      .o_front (w_front[v]),
      .o_full  (w_full[v]),
      .o_empty (w_empty[v])
    );
  end

  // Grant beats discard: only one credit can leave per cycle.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_v   = '0;
    w_dis_vld = 1'b0;
    w_dis_v   = '0;
    w_ovf     = 1'b0;
    for (int i = 0; i < VCH_NUM; i++) begin
      if (!w_gnt_vld && grant_i[i] && w_req[i]) begin
        w_gnt_vld = 1'b1;
        w_gnt_v   = VCH_W'(i);
      end
    end
    for (int i = 0; i < VCH_NUM; i++) begin
      if (!w_gnt_vld && !w_dis_vld && w_bad[i]) begin
        w_dis_vld = 1'b1;
        w_dis_v   = VCH_W'(i);
      end
      if (valid_i && (vch_i == VCH_W'(i)) && w_full[i] && !w_pop[i]) w_ovf = 1'b1;
    end
  end

  always_comb begin
    w_rc_vld = 1'b0;
    w_rc_win = '0;
    w_idx    = '0;
    for (int i = 0; i < VCH_NUM; i++) begin
      w_idx = VCH_W'((int'(r_rc_ptr) + i) % VCH_NUM);
      if (!w_rc_vld && w_elig[w_idx]) begin
        w_rc_vld = 1'b1;
        w_rc_win = w_idx;
      end
    end
  end

  assign rc_en_o   = w_rc_vld;
  assign rc_addr_o = w_rc_vld ? w_front[w_rc_win][ENTRY_W-1:0] : '0;
  assign rc_vch_o  = w_rc_vld ? ENTRY_W'(w_rc_win) : '0;
  assign req_o     = w_req;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < VCH_NUM; i++) r_state[i] <= VC_IDLE;
      r_port       <= '0;
      r_ovc        <= '0;
      r_rc_ptr     <= '0;
      r_flit_vld   <= 1'b0;
      r_credit     <= 1'b0;
      r_credit_vch <= '0;
      r_flit       <= '0;
      r_out_port   <= '0;
      r_out_vch    <= '0;
      r_err        <= 1'b0;
    end else begin
      for (int i = 0; i < VCH_NUM; i++) begin
        if (w_rc_vld && (w_rc_win == VCH_W'(i))) begin
          r_state[i] <= VC_ACTIVE;
          r_port[i]  <= rc_port_i;
          r_ovc[i]   <= rc_vch_i;
        end else if ((r_state[i] == VC_IDLE) && w_elig[i]) begin
          r_state[i] <= VC_RC;
        end else if ((r_state[i] == VC_ACTIVE) && w_gnt_vld && (w_gnt_v == VCH_W'(i)) &&
                     ft_is_tail(w_front[i][FLIT_W-1 -: 2])) begin
          r_state[i] <= VC_IDLE;
        end
      end
      if (w_rc_vld) r_rc_ptr <= (w_rc_win == VCH_W'(VCH_NUM-1)) ? '0 : w_rc_win + 1'b1;
      r_flit_vld <= w_gnt_vld;
      r_credit   <= w_gnt_vld || w_dis_vld;
      if (w_gnt_vld) begin
        r_flit       <= w_front[w_gnt_v];
        r_out_port   <= r_port[w_gnt_v];
        r_out_vch    <= r_ovc[w_gnt_v];
        r_credit_vch <= w_gnt_v;
      end else if (w_dis_vld) begin
        r_credit_vch <= w_dis_v;
      end
      if (w_ovf || w_dis_vld) r_err <= 1'b1;
    end
  end

  assign flit_vld_o   = r_flit_vld;
  assign flit_o       = r_flit;
  assign out_port_o   = r_out_port;
  assign out_vch_o    = r_out_vch;
  assign credit_o     = r_credit;
  assign credit_vch_o = r_credit_vch;
  assign err_o        = r_err;
endmodule

// File: tb/tb_inbuf_vc.sv
// Directed bench for inbuf_vc: routing latency, RC round-robin, packets, overflow, stray body, reset.
module tb_inbuf_vc;
  import noc_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                valid_i = 1'b0;
  logic [FLIT_W-1:0]   flit_i = '0;
  logic                vch_i = 1'b0;
  logic                credit_o;
  logic                credit_vch_o;
  logic                rc_en_o;
  logic [ENTRY_W-1:0]  rc_addr_o;
  logic [ENTRY_W-1:0]  rc_vch_o;
  logic [PORT_W-1:0]   rc_port_i;
  logic                rc_vch_i;
  logic [1:0]          req_o;
  logic [2*PORT_W-1:0] req_port_o;
  logic [1:0]          grant_i;
  logic                flit_vld_o;
  logic [FLIT_W-1:0]   flit_o;
  logic [PORT_W-1:0]   out_port_o;
  logic                out_vch_o;
  logic                err_o;

  logic       auto_g = 1'b0;
  logic [1:0] gman = 2'b00;
  logic [2:0] exp_port = 3'd0;

  // Stand-in route compute: port = addr[2:0], output VC = addr[4].
  assign rc_port_i = rc_addr_o[2:0];
  assign rc_vch_i  = rc_addr_o[4];
  assign grant_i   = auto_g ? req_o : gman;

  inbuf_vc #(.VCH_NUM(2), .BUF_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .flit_i(flit_i), .vch_i(vch_i),
    .credit_o(credit_o), .credit_vch_o(credit_vch_o), .rc_en_o(rc_en_o),
    .rc_addr_o(rc_addr_o), .rc_vch_o(rc_vch_o), .rc_port_i(rc_port_i), .rc_vch_i(rc_vch_i),
    .req_o(req_o), .req_port_o(req_port_o), .grant_i(grant_i), .flit_vld_o(flit_vld_o),
    .flit_o(flit_o), .out_port_o(out_port_o), .out_vch_o(out_vch_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int n_rc = 0, n_vld = 0, n_cred = 0, n_cred1 = 0, n_portok = 0;
  int s_rc, s_vld, s_cred, s_cred1, s_portok;

  always @(negedge clk) begin
    if (rc_en_o) n_rc++;
    if (flit_vld_o) n_vld++;
    if (credit_o) n_cred++;
    if (credit_o && credit_vch_o) n_cred1++;
    if (flit_vld_o && out_port_o == exp_port) n_portok++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic drv(input logic [1:0] ft, input logic [7:0] a, input logic v);
    valid_i = 1'b1; flit_i = {ft, a}; vch_i = v;
  endtask

  task automatic snap;
    s_rc = n_rc; s_vld = n_vld; s_cred = n_cred; s_cred1 = n_cred1; s_portok = n_portok;
  endtask

  initial begin
    step; step;
    chk("rst_flit_vld", flit_vld_o, 0);
    chk("rst_credit", credit_o, 0);
    chk("rst_req", req_o, 0);
    chk("rst_rc_en", rc_en_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_flit", flit_o, 0);
    rst_n = 1'b1; auto_g = 1'b1;

    // single HEADTAIL on VC0
    drv(FT_HEADTAIL, 8'h21, 1'b0); step; valid_i = 1'b0;
    chk("t1_rc_en", rc_en_o, 1);
    chk("t1_rc_addr", rc_addr_o, 8'h21);
    chk("t1_rc_vch", rc_vch_o, 0);
    step;
    chk("t1_req", req_o, 2'b01);
    chk("t1_req_port", req_port_o[2:0], 3'd1);
    step;
    chk("t1_vld", flit_vld_o, 1);
    chk("t1_flit", flit_o, 10'h321);
    chk("t1_port", out_port_o, 3'd1);
    chk("t1_ovch", out_vch_o, 0);
    chk("t1_credit", credit_o, 1);
    chk("t1_credit_vch", credit_vch_o, 0);
    step;
    chk("t1_vld_off", flit_vld_o, 0);
    chk("t1_idle_req", req_o, 0);
    chk("t1_idle_rc", rc_en_o, 0);

    // RC contention and round-robin
    rst_n = 1'b0; auto_g = 1'b0; step; rst_n = 1'b1;
    drv(FT_HEADTAIL, 8'h10, 1'b1); step;
    drv(FT_HEADTAIL, 8'h32, 1'b1);
    chk("t2_rc_p", rc_vch_o, 1); step;
    chk("t2_req_p", req_o, 2'b10);
    gman = 2'b10; drv(FT_HEADTAIL, 8'h43, 1'b0); step;
    gman = 2'b00; valid_i = 1'b0;
    chk("t2_flit_p", flit_o, 10'h310);
    chk("t2_ovch_p", out_vch_o, 1);
    chk("t2_c1_en", rc_en_o, 1);
    chk("t2_c1_vch", rc_vch_o, 0);
    chk("t2_c1_addr", rc_addr_o, 8'h43);
    step;
    chk("t2_c2_vch", rc_vch_o, 1);
    chk("t2_c2_addr", rc_addr_o, 8'h32);
    step;
    chk("t2_req_both", req_o, 2'b11);
    gman = 2'b11; step;
    chk("t2_mh_flit", flit_o, 10'h343);
    chk("t2_mh_cvch", credit_vch_o, 0);
    step;
    chk("t2_q_flit", flit_o, 10'h332);
    chk("t2_q_port", out_port_o, 3'd2);
    chk("t2_q_cvch", credit_vch_o, 1);
    gman = 2'b00; drv(FT_HEADTAIL, 8'h65, 1'b0); step;
    drv(FT_HEADTAIL, 8'h76, 1'b0);
    chk("t2_u_vch", rc_vch_o, 0); step;
    chk("t2_u_req", req_o, 2'b01);
    gman = 2'b01; drv(FT_HEADTAIL, 8'h07, 1'b1); step;
    gman = 2'b00; valid_i = 1'b0;
    chk("t2_rr_vch", rc_vch_o, 1);
    chk("t2_rr_addr", rc_addr_o, 8'h07);
    step;
    chk("t2_rr2_vch", rc_vch_o, 0);
    chk("t2_rr2_addr", rc_addr_o, 8'h76);
    auto_g = 1'b1;
    repeat (6) step;

    // 4-flit packet on VC1
    exp_port = 3'd2; snap;
    drv(FT_HEAD, 8'h5A, 1'b1); step;
    drv(FT_BODY, 8'hA1, 1'b1); step;
    drv(FT_BODY, 8'hA2, 1'b1); step;
    drv(FT_TAIL, 8'hA3, 1'b1); step;
    valid_i = 1'b0; repeat (6) step;
    chk("t3_rc_cnt", n_rc - s_rc, 1);
    chk("t3_vld_cnt", n_vld - s_vld, 4);
    chk("t3_cred_cnt", n_cred - s_cred, 4);
    chk("t3_cred1_cnt", n_cred1 - s_cred1, 4);
    chk("t3_port_cnt", n_portok - s_portok, 4);
    chk("t3_last_flit", flit_o, 10'h2A3);

    // stray BODY to IDLE VC1
    snap;
    drv(FT_BODY, 8'h11, 1'b1); step; valid_i = 1'b0;
    chk("t5_rc_en", rc_en_o, 0);
    chk("t5_req", req_o, 0);
    step;
    chk("t5_credit", credit_o, 1);
    chk("t5_credit_vch", credit_vch_o, 1);
    chk("t5_vld", flit_vld_o, 0);
    chk("t5_err", err_o, 1);
    step;
    chk("t5_rc_cnt", n_rc - s_rc, 0);

    // overflow on VC0
    rst_n = 1'b0; auto_g = 1'b0; gman = 2'b00; step; rst_n = 1'b1;
    drv(FT_HEAD, 8'h21, 1'b0); step;
    drv(FT_BODY, 8'h01, 1'b0); step;
    drv(FT_BODY, 8'h02, 1'b0); step;
    drv(FT_BODY, 8'h03, 1'b0); step;
    drv(FT_BODY, 8'h04, 1'b0);
    chk("t4_err_pre", err_o, 0);
    chk("t4_req", req_o, 2'b01);
    step; valid_i = 1'b0;
    chk("t4_err", err_o, 1);
    snap; gman = 2'b01;
    repeat (4) step;
    gman = 2'b00;
    chk("t4_last_flit", flit_o, 10'h003);
    chk("t4_drained", req_o, 0);
    step;
    chk("t4_vld_cnt", n_vld - s_vld, 4);

    // reset mid-packet with 3 flits buffered on VC1
    drv(FT_HEAD, 8'h33, 1'b1); step;
    drv(FT_BODY, 8'h34, 1'b1); step;
    drv(FT_BODY, 8'h35, 1'b1); step;
    valid_i = 1'b0; rst_n = 1'b0; step; rst_n = 1'b1;
    chk("t6_vld", flit_vld_o, 0);
    chk("t6_credit", credit_o, 0);
    chk("t6_cvch", credit_vch_o, 0);
    chk("t6_rc_en", rc_en_o, 0);
    chk("t6_rc_addr", rc_addr_o, 0);
    chk("t6_req", req_o, 0);
    chk("t6_req_port", req_port_o, 0);
    chk("t6_flit", flit_o, 0);
    chk("t6_port", out_port_o, 0);
    chk("t6_ovch", out_vch_o, 0);
    chk("t6_err", err_o, 0);
    auto_g = 1'b1;
    drv(FT_HEADTAIL, 8'h21, 1'b1); step; valid_i = 1'b0;
    chk("t6_rc_en2", rc_en_o, 1);
    chk("t6_rc_vch2", rc_vch_o, 1);
    step; step;
    chk("t6_vld2", flit_vld_o, 1);
    chk("t6_flit2", flit_o, 10'h321);
    chk("t6_port2", out_port_o, 3'd1);
    chk("t6_cvch2", credit_vch_o, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
